// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory slice.
// Holds the controller state encoding and the fill bit of the default halt word
// (the halt word defaults to all-ones at whatever INST_W the instance uses).
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Every bit of the default halt word takes this value.
  localparam logic HALT_FILL_BIT = 1'b1;

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x INST_W storage, one synchronous write and one synchronous read port.
// Ports: clk_i; wr_en_i/wr_addr_i/wr_data_i write port; rd_en_i/rd_addr_i read request,
//        rd_data_o registered read data (holds its value while rd_en_i is low).
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int INST_W = 9,
  parameter int AW     = 8
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [INST_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [INST_W-1:0] rd_data_o
);

  // Contents are deliberately not reset; the caller tracks which words are valid.
  logic [INST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/imem_sync.sv
// imem_sync: loadable instruction memory with a 1-cycle synchronous fetch port.
// Ports: CLK, reset (async, active-high); fetch rd_en/PC -> rd_ready, inst, inst_valid, is_halt;
//        load ld_start/ld_valid/ld_data/ld_last -> ld_ready, ld_err (sticky), ld_count.
module imem_sync
  import imem_pkg::*;
#(
  parameter int                PC_W      = 8,
  parameter int                INST_W    = 9,
  parameter int                DEPTH     = 256,
  parameter logic [INST_W-1:0] HALT_WORD = {INST_W{HALT_FILL_BIT}}
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [PC_W-1:0]   PC,
  output logic              rd_ready,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              is_halt,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [INST_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_err,
  output logic [PC_W:0]     ld_count
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W:0] DEPTH_W = (PC_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [PC_W:0]     ptr_q, ptr_d;        // next write slot, doubles as the word count
  logic [DEPTH-1:0]  vld_q, vld_d;        // per-word "written since last load start"
  logic              err_q, err_d;
  logic              hit_q, hit_d;        // last accepted fetch hit a valid in-range word
  logic              ival_q, ival_d;

  logic              rd_acc, wr_en, pc_in_rng;
  logic [AW-1:0]     pc_idx, wr_idx;
  logic [INST_W-1:0] arr_rdata;

  assign ld_ready  = (state_q == ST_LOAD) && (ptr_q < DEPTH_W);
  assign rd_ready  = (state_q == ST_RUN);
  assign pc_in_rng = ({1'b0, PC} < DEPTH_W);
  assign pc_idx    = PC[AW-1:0];
  assign wr_idx    = ptr_q[AW-1:0];

  // A load restart takes priority: a fetch or load beat in the same cycle is discarded.
  assign rd_acc = rd_en && rd_ready && !ld_start;
  assign wr_en  = ld_valid && ld_ready && !ld_start;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    err_d   = err_q;
    hit_d   = hit_q;
    ival_d  = rd_acc;
    if (rd_acc) begin
      hit_d = pc_in_rng && vld_q[pc_idx];
    end
    if (ld_start) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      vld_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == ST_LOAD && ld_valid) begin
      if (ld_ready) begin
        ptr_d         = ptr_q + 1'b1;
        vld_d[wr_idx] = 1'b1;
      end else begin
        err_d = 1'b1;  // memory full: beat dropped
      end
      // ld_last completes the load even when its beat was dropped.
      if (ld_last) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
      ival_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      ival_q  <= ival_d;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .INST_W(INST_W),
    .AW    (AW)
  ) u_array (
    .clk_i    (CLK),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_idx),
    .wr_data_i(ld_data),
    .rd_en_i  (rd_acc && pc_in_rng),
    .rd_addr_i(pc_idx),
    .rd_data_o(arr_rdata)
  );

  // The array output is not resettable, so a miss/reset selects the halt word here.
  // Both hit_q and arr_rdata only change on an accepted fetch, so inst holds otherwise.
  assign inst       = hit_q ? arr_rdata : HALT_WORD;
  assign inst_valid = ival_q;
  assign is_halt    = ival_q && (inst == HALT_WORD);
  assign ld_err     = err_q;
  assign ld_count   = ptr_q;

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed bench for imem_sync (default instance plus a DEPTH=4 instance).
// Ports: none; both instances share stimulus, outputs are checked against hand-computed values.
module tb_imem_sync;

  logic       CLK = 1'b0;
  logic       reset, rd_en, ld_start, ld_valid, ld_last;
  logic [7:0] PC;
  logic [8:0] ld_data;

  logic       rd_ready, inst_valid, is_halt, ld_ready, ld_err;
  logic [8:0] inst, ld_count;
  logic       u4_rd_ready, u4_inst_valid, u4_is_halt, u4_ld_ready, u4_ld_err;
  logic [8:0] u4_inst, u4_ld_count;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] wtab [12] = '{9'h001, 9'h0A5, 9'h15A, 9'h033, 9'h0CC, 9'h100,
                            9'h0FF, 9'h1FE, 9'h055, 9'h0AA, 9'h123, 9'h1FF};

  always #5 CLK = ~CLK;

  imem_sync u_dut (
    .CLK(CLK), .reset(reset), .rd_en(rd_en), .PC(PC), .rd_ready(rd_ready),
    .inst(inst), .inst_valid(inst_valid), .is_halt(is_halt),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_err(ld_err), .ld_count(ld_count)
  );

  imem_sync #(.DEPTH(4)) u_dut4 (
    .CLK(CLK), .reset(reset), .rd_en(rd_en), .PC(PC), .rd_ready(u4_rd_ready),
    .inst(u4_inst), .inst_valid(u4_inst_valid), .is_halt(u4_is_halt),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(u4_ld_ready), .ld_err(u4_ld_err), .ld_count(u4_ld_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [7:0] addr);
    rd_en = 1'b1;
    PC    = addr;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rd_en = 1'b0; PC = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    tick(); tick();
    check_eq("rst_inst",       inst,       9'h1FF);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_is_halt",    is_halt,    0);
    check_eq("rst_rd_ready",   rd_ready,   0);
    check_eq("rst_ld_ready",   ld_ready,   0);
    check_eq("rst_ld_err",     ld_err,     0);
    check_eq("rst_ld_count",   ld_count,   0);
    reset = 1'b0;
    tick();

    // 12-word load, final word is the halt encoding
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    check_eq("load_ld_ready0", ld_ready, 1);
    check_eq("load_count0",    ld_count, 0);
    check_eq("load_rd_ready0", rd_ready, 0);
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1; ld_data = wtab[i]; ld_last = (i == 11);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("load12_count",    ld_count, 12);
    check_eq("load12_rd_ready", rd_ready, 1);
    check_eq("load12_ld_ready", ld_ready, 0);
    check_eq("load12_ld_err",   ld_err,   0);

    // back-to-back fetches, one result per cycle
    rd_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      PC = 8'(i);
      tick();
      check_eq($sformatf("fetch%0d_inst", i),  inst,       wtab[i]);
      check_eq($sformatf("fetch%0d_valid", i), inst_valid, 1);
      check_eq($sformatf("fetch%0d_halt", i),  is_halt,    (i == 11) ? 1 : 0);
    end
    rd_en = 1'b0;

    fetch(8'd12);
    check_eq("unloaded_inst", inst,    9'h1FF);
    check_eq("unloaded_halt", is_halt, 1);
    fetch(8'd200);
    check_eq("pc200_inst", inst,    9'h1FF);
    check_eq("pc200_halt", is_halt, 1);
    fetch(8'd3);
    check_eq("pc3_inst", inst,    9'h033);
    check_eq("pc3_halt", is_halt, 0);

    // idle cycles in RUN: no result, instruction held
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("idle%0d_valid", k), inst_valid, 0);
      check_eq($sformatf("idle%0d_inst", k),  inst,       9'h033);
      check_eq($sformatf("idle%0d_halt", k),  is_halt,    0);
    end

    // fetch colliding with a load restart is dropped
    rd_en = 1'b1; PC = 8'd5; ld_start = 1'b1;
    tick();
    rd_en = 1'b0; ld_start = 1'b0;
    check_eq("coll_valid",    inst_valid, 0);
    check_eq("coll_rd_ready", rd_ready,   0);
    check_eq("coll_ld_ready", ld_ready,   1);
    check_eq("coll_count",    ld_count,   0);
    check_eq("coll_inst",     inst,       9'h033);
    ld_valid = 1'b1; ld_data = 9'h0A0; ld_last = 1'b0; tick();
    ld_data = 9'h0A1; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("reload2_count", ld_count, 2);
    fetch(8'd1);
    check_eq("reload2_pc1", inst, 9'h0A1);
    fetch(8'd5);
    check_eq("stale_pc5_inst", inst,    9'h1FF);
    check_eq("stale_pc5_halt", is_halt, 1);
    fetch(8'd0);
    check_eq("reload2_pc0", inst, 9'h0A0);

    // overfill the DEPTH=4 instance with 6 words
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_data = 9'h140 + 9'(i); ld_last = (i == 5);
      #1;
      check_eq($sformatf("d4_beat%0d_ready", i), u4_ld_ready, (i < 4) ? 1 : 0);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("d4_ld_err",    u4_ld_err,   1);
    check_eq("d4_ld_count",  u4_ld_count, 4);
    check_eq("d4_rd_ready",  u4_rd_ready, 1);
    check_eq("d4_ld_ready",  u4_ld_ready, 0);
    check_eq("d256_count6",  ld_count,    6);
    check_eq("d256_ld_err",  ld_err,      0);
    fetch(8'd3);
    check_eq("d4_pc3_inst", u4_inst, 9'h143);
    fetch(8'd4);
    check_eq("d4_pc4_inst",   u4_inst,    9'h1FF);
    check_eq("d4_pc4_halt",   u4_is_halt, 1);
    check_eq("d256_pc4_inst", inst,       9'h144);

    // reset in the middle of a load
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 9'h0E1 + 9'(i); tick();
    end
    ld_valid = 1'b0;
    check_eq("midload_count", ld_count, 3);
    reset = 1'b1;
    #1;
    check_eq("arst_inst",     inst,       9'h1FF);
    check_eq("arst_valid",    inst_valid, 0);
    check_eq("arst_count",    ld_count,   0);
    check_eq("arst_ld_ready", ld_ready,   0);
    check_eq("arst_rd_ready", rd_ready,   0);
    check_eq("arst_d4_err",   u4_ld_err,  0);
    tick();
    reset = 1'b0;
    tick();
    fetch(8'd0);
    check_eq("idle_fetch_valid", inst_valid, 0);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    fetch(8'd0);
    check_eq("load_fetch_valid", inst_valid, 0);
    ld_valid = 1'b1; ld_data = 9'h077; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("reload1_count",    ld_count, 1);
    check_eq("reload1_rd_ready", rd_ready, 1);
    fetch(8'd0);
    check_eq("reload1_pc0_inst",  inst,       9'h077);
    check_eq("reload1_pc0_valid", inst_valid, 1);
    fetch(8'd1);
    check_eq("reload1_pc1_inst", inst, 9'h1FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 Parameter PC_W, default 8, width of program counter and load address.
REQ-002 Parameter INST_W, default 9, instruction word width.
REQ-003 Parameter DEPTH, default 256, number of stored words; SHALL satisfy 1 <= DEPTH <= 2**PC_W.
REQ-004 Parameter HALT_WORD, default all-ones of INST_W, halt encoding.
REQ-005 CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rd_en  input  1  fetch request for address PC.
REQ-008 PC  input  PC_W  fetch address.
REQ-009 rd_ready  output  1  fetch accepted when rd_en && rd_ready.
REQ-010 inst  output  INST_W  fetched instruction.
REQ-011 inst_valid  output  1  inst holds the result of the fetch accepted last cycle.
REQ-012 is_halt  output  1  inst_valid && inst == HALT_WORD.
REQ-013 ld_start  input  1  pulse: begin program load at address 0.
REQ-014 ld_valid  input  1  ld_data carries a word.
REQ-015 ld_data  input  INST_W  word to load.
REQ-016 ld_last  input  1  qualifies final word of a load.
REQ-017 ld_ready  output  1  load word accepted when ld_valid && ld_ready.
REQ-018 ld_err  output  1  sticky: a word was offered while memory full.
REQ-019 ld_count  output  PC_W+1  words written in current/last load.

Function
REQ-020 FSM states IDLE, LOAD, RUN; reset state IDLE.
REQ-021 IDLE->LOAD on ld_start; LOAD->RUN on accepted word with ld_last; RUN->LOAD on ld_start; IDLE->RUN never without a completed load.
REQ-022 On entering LOAD: load pointer := 0, ld_count := 0, all per-word valid bits := 0, ld_err := 0.
REQ-023 ld_ready = (state==LOAD) && (pointer < DEPTH).
REQ-024 Accepted load word: mem[pointer] := ld_data, valid[pointer] := 1, pointer and ld_count increment.
REQ-025 ld_valid in LOAD with pointer == DEPTH: word dropped, ld_err := 1; ld_last on such a dropped beat still moves FSM to RUN.
REQ-026 ld_start while in LOAD restarts the load per REQ-022.
REQ-027 rd_ready = (state==RUN); fetches in IDLE/LOAD are ignored.
REQ-028 Read latency exactly 1 cycle: accepted fetch at edge N yields inst and inst_valid=1 after edge N+1 ... i.e. visible in cycle N+1.
REQ-029 inst = mem[PC] if PC < DEPTH and valid[PC]; else HALT_WORD (unloaded or out-of-range address).
REQ-030 No accepted fetch in a cycle: inst_valid := 0, inst holds previous value.
REQ-031 Back-to-back fetches SHALL sustain one instruction per cycle.
REQ-032 ld_start in RUN with a fetch accepted the same cycle: fetch is dropped, inst_valid := 0 next cycle.

Reset
REQ-033 Reset mid-load or mid-fetch aborts immediately: state IDLE, inst := HALT_WORD, inst_valid := 0, ld_err := 0, ld_count := 0, pointer := 0, all valid bits := 0.
REQ-034 Memory array contents are not reset; validity is governed solely by valid bits.

Structure
REQ-035 Shared package imem_pkg holds FSM state enum (IDLE, LOAD, RUN) and default HALT encoding constant.
REQ-036 One sub-module imem_array: DEPTH x INST_W storage, one synchronous write port, one synchronous read port; valid bits and FSM live in imem_sync.

Verification
REQ-037 Load 12 words (last = 1_1111_1111, ld_last on 12th) -> ld_count=12, state RUN; fetch PC=0..11 back-to-back -> words in order, 1-cycle latency, is_halt only on PC=11.
REQ-038 After 12-word load, fetch PC=200 -> inst=HALT_WORD, is_halt=1.
REQ-039 DEPTH=4 instance, offer 6 words with ld_last on 6th -> ld_ready low after 4, ld_err=1, ld_count=4, RUN entered.
REQ-040 Assert reset during LOAD after 3 words -> all outputs at reset values; fetch ignored until a new load completes; fetch PC=0 after 1-word reload returns new word.
REQ-041 In RUN, rd_en with PC=5 and ld_start same cycle -> inst_valid=0 next cycle, rd_ready=0, valid bits cleared.
REQ-042 rd_en held low in RUN -> inst_valid=0, inst unchanged for all idle cycles.
